bypass_scoreboard_id: RTL and testbench
=======================================

// Module: bypass_scoreboard_id
// PURPOSE
//  Parametrised ID-stage forwarding and hazard controller for the segre pipeline.
//  Keeps its own shadow pipeline of in-flight destination tags (one entry per
//  forwarding stage: EX, MEM, WB, ...) and the stage at which each result becomes
//  available. For each decoded source it picks the forward path or the RF, and
//  raises a stall when the youngest producer has not yet produced its data.
//  Supports N sources and multi-cycle producers such as loads and mul.
// PARAMETERS
//  NUM_SRC   3  source operands per instruction (rs1, rs2, rs3)
//  NUM_FWD   3  forwarding stages after ID (0=EX, 1=MEM, 2=WB)
//  REG_SIZE  5  register identifier width (from segre_pkg)
//  COUNT_W  32  stall performance counter width
//  SEL_W = $clog2(NUM_FWD+1); STG_W = $clog2(NUM_FWD) (min 1), both localparam
// PORTS
//  clk_i             in   1                 clock
//  rsn_i             in   1                 async reset, active low
//  id_valid_i        in   1                 valid instruction in ID
//  id_src_i          in   NUM_SRC*REG_SIZE  source regs, src j at [j*REG_SIZE +: REG_SIZE]
//  id_rd_src_i       in   NUM_SRC           source j is actually read
//  id_wr_en_i        in   1                 ID instruction writes a register
//  id_dst_i          in   REG_SIZE          ID destination register
//  id_ready_stage_i  in   STG_W             first stage whose output holds the result (0=EX)
//  advance_i         in   1                 pipeline moves one step this cycle
//  flush_i           in   1                 kill the instruction currently in ID
//  fwd_sel_o         out  NUM_SRC*SEL_W     per source: 0=RF, k+1=forward from stage k
//  stall_o           out  1                 RAW hazard, hold ID/IF and inject bubble
//  entry_valid_o     out  NUM_FWD           shadow-pipeline occupancy (debug/verif)
//  stall_cnt_o       out  COUNT_W           saturating count of stall cycles
// BEHAVIOUR
//  Reset (async, rsn_i=0): all entries invalid, stall_cnt_o=0. Outputs then read
//   fwd_sel_o=0, stall_o=0 and entry_valid_o=0 immediately, not at the next edge.
//  Entry k fields: {valid, dst, rdy}. Entry 0 is EX (youngest); entry NUM_FWD-1 is oldest.
//  id_ready_stage_i >= NUM_FWD is clamped to NUM_FWD-1 on capture.
//  Per clk_i edge, when advance_i=1:
//   - entry[k+1] <= entry[k] for every k; the oldest entry drops out.
//   - entry[0] <= {1, id_dst_i, rdy} only if id_valid_i & id_wr_en_i & id_dst_i!=0
//     & !stall_o & !flush_i. Otherwise entry[0] becomes a bubble (valid=0).
//  When advance_i=0, all entries hold. flush_i has no effect on entries 1..NUM_FWD-1.
//  Lookup is combinational, with zero latency from ID inputs and current state:
//   - Source j matches entry k if id_rd_src_i[j], entry[k].valid, src!=0 and src==entry[k].dst.
//   - Only the youngest match (lowest k) counts; older matches are ignored.
//   - Youngest match k with k >= rdy: fwd_sel j = k+1. With k < rdy: hazard_j=1, fwd_sel j = 0.
//   - No match: fwd_sel j = 0.
//  stall_o = id_valid_i & |hazard_j. fwd_sel_o does not depend on id_valid_i.
//  Because the stall bubble enters entry 0, the producer advances each cycle.
//   The stall therefore clears on its own after (rdy - k) advancing cycles.
//  stall_cnt_o increments by 1 on each edge where stall_o=1 and saturates at all-ones.
//  Simultaneous events: flush_i wins over a new capture. A stalled ID never
//   captures. advance_i=0 freezes entries, but the counter still counts stall cycles.
// TESTING
//  T1 ALU chain: add x5 (rdy=0) issues, then add x6,x5,x5 next cycle
//     -> fwd_sel src0=src1=1, stall_o=0.
//  T2 load-use: lw x7 (rdy=1), then add x8,x7,x1
//     -> stall_o=1 for 1 cycle, then fwd_sel src0=2, src1=0; stall_cnt_o=1.
//  T3 youngest wins: x9 written by entries in EX and WB, consumer reads x9 -> fwd_sel=1.
//  T4 x0: entry with dst 0 never captured; source x0 -> fwd_sel=0, stall_o=0.
//  T5 hold/flush: advance_i=0 for 3 cycles -> entry_valid_o unchanged.
//     flush_i+advance_i with a writer in ID -> entry_valid_o[0]=0 next cycle.
//  T6 reset mid-stall, with COUNT_W=4: 20 stall cycles -> stall_cnt_o=15.
//     Then rsn_i=0 -> counter=0, entry_valid_o=0, stall_o=0 immediately.

Source files
------------

// File: rtl/bypass_scoreboard_id_if.sv
// ID-stage bundle between decode and the bypass scoreboard.
// Master is the decode side; slave is the scoreboard.
interface bypass_scoreboard_id_if #(
    parameter int NUM_SRC  = 3,
    parameter int NUM_FWD  = 3,
    parameter int REG_SIZE = 5,
    parameter int COUNT_W  = 32
);
    localparam int SEL_W = $clog2(NUM_FWD + 1);
    localparam int STG_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;

    logic                        id_valid_i;
    logic [NUM_SRC*REG_SIZE-1:0] id_src_i;
    logic [NUM_SRC-1:0]          id_rd_src_i;
    logic                        id_wr_en_i;
    logic [REG_SIZE-1:0]         id_dst_i;
    logic [STG_W-1:0]            id_ready_stage_i;
    logic                        advance_i;
    logic                        flush_i;
    logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o;
    logic                        stall_o;
    logic [NUM_FWD-1:0]          entry_valid_o;
    logic [COUNT_W-1:0]          stall_cnt_o;

    modport master (
        output id_valid_i, id_src_i, id_rd_src_i, id_wr_en_i,
        output id_dst_i, id_ready_stage_i, advance_i, flush_i,
        input  fwd_sel_o, stall_o, entry_valid_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_src_i, id_rd_src_i, id_wr_en_i,
        input  id_dst_i, id_ready_stage_i, advance_i, flush_i,
        output fwd_sel_o, stall_o, entry_valid_o, stall_cnt_o
    );
endinterface

// File: rtl/bypass_scoreboard_id.sv
// ID-stage forwarding/hazard controller with a shadow pipeline of
// in-flight destination tags and per-entry result-ready stage.
module bypass_scoreboard_id #(
    parameter int NUM_SRC  = 3,
    parameter int NUM_FWD  = 3,
    parameter int REG_SIZE = 5,
    parameter int COUNT_W  = 32
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    bypass_scoreboard_id_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_FWD + 1);
    localparam int STG_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;

    typedef struct packed {
        logic                vld;
        logic [REG_SIZE-1:0] dst;
        logic [STG_W-1:0]    rdy;
    } ent_t;

    ent_t [NUM_FWD-1:0]       ent_q, ent_d;
    logic [COUNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic [NUM_SRC-1:0]       hz;
    logic [REG_SIZE-1:0]      src;
    logic [STG_W-1:0]         rdy_cap;
    logic [NUM_FWD-1:0]       ev;
    logic                     stall;
    logic                     cap;

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        sel = '0;
        hz  = '0;
        src = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            src = bus.id_src_i[j*REG_SIZE +: REG_SIZE];
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (bus.id_rd_src_i[j] && ent_q[k].vld &&
                    src != '0 && src == ent_q[k].dst) begin
                    if (k >= int'(ent_q[k].rdy)) begin
                        sel[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        hz[j] = 1'b0;
                    end else begin
                        sel[j*SEL_W +: SEL_W] = '0;
                        hz[j] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = bus.id_valid_i & (|hz);

    assign rdy_cap = (int'(bus.id_ready_stage_i) >= NUM_FWD)
                   ? STG_W'(NUM_FWD - 1) : bus.id_ready_stage_i;

    assign cap = bus.id_valid_i & bus.id_wr_en_i & (bus.id_dst_i != '0)
               & ~stall & ~bus.flush_i;

    always_comb begin
        ent_d = ent_q;
        if (bus.advance_i) begin
            for (int k = NUM_FWD - 1; k >= 1; k--) begin
                ent_d[k] = ent_q[k-1];
            end
            ent_d[0] = '0;
            if (cap) begin
                ent_d[0] = {1'b1, bus.id_dst_i, rdy_cap};
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != '1) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_comb begin
        ev = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            ev[k] = ent_q[k].vld;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            ent_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.fwd_sel_o     = sel;
    assign bus.stall_o       = stall;
    assign bus.entry_valid_o = ev;
    assign bus.stall_cnt_o   = cnt_q;
endmodule

// File: tb/tb_bypass_scoreboard_id.sv
// Bench for bypass_scoreboard_id: directed scenarios plus random
// traffic against a producer-list model of in-flight results.
module tb_bypass_scoreboard_id;
    localparam int NS = 3;
    localparam int NF = 3;
    localparam int RS = 5;
    localparam int CW = 4;
    localparam int SW = 2;
    localparam int TW = 2;

    logic clk;
    logic rsn;
    int   checks;
    int   failures;

    bypass_scoreboard_id_if #(
        .NUM_SRC(NS), .NUM_FWD(NF), .REG_SIZE(RS), .COUNT_W(CW)
    ) bus ();

    bypass_scoreboard_id #(
        .NUM_SRC(NS), .NUM_FWD(NF), .REG_SIZE(RS), .COUNT_W(CW)
    ) dut (
        .clk_i(clk),
        .rsn_i(rsn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each in-flight producer: register, ready stage, advances since issue.
    typedef struct {
        int dst;
        int rdy;
        int pos;
    } rec_t;

    rec_t         q[$];
    int           mcnt;
    logic         m_stall;
    logic [NS*SW-1:0] m_sel;
    logic [NF-1:0]    m_ev;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mcnt = 0;
    endtask

    task automatic model_eval();
        logic any_hz;
        any_hz = 1'b0;
        m_sel  = '0;
        m_ev   = '0;
        foreach (q[i]) m_ev[q[i].pos] = 1'b1;
        for (int j = 0; j < NS; j++) begin
            int s;
            int best;
            int brdy;
            s    = int'(bus.id_src_i[j*RS +: RS]);
            best = -1;
            brdy = 0;
            if (bus.id_rd_src_i[j] && s != 0) begin
                foreach (q[i]) begin
                    if (q[i].dst == s && (best < 0 || q[i].pos < best)) begin
                        best = q[i].pos;
                        brdy = q[i].rdy;
                    end
                end
            end
            if (best >= 0) begin
                if (best >= brdy) m_sel[j*SW +: SW] = SW'(best + 1);
                else any_hz = 1'b1;
            end
        end
        m_stall = bus.id_valid_i & any_hz;
    endtask

    task automatic model_update();
        rec_t nq[$];
        rec_t r;
        if (bus.advance_i) begin
            foreach (q[i]) begin
                r = q[i];
                r.pos++;
                if (r.pos < NF) nq.push_back(r);
            end
            q = nq;
            if (bus.id_valid_i && bus.id_wr_en_i && bus.id_dst_i != 0 &&
                !m_stall && !bus.flush_i) begin
                r.dst = int'(bus.id_dst_i);
                r.rdy = (int'(bus.id_ready_stage_i) > NF - 1)
                      ? NF - 1 : int'(bus.id_ready_stage_i);
                r.pos = 0;
                q.push_back(r);
            end
        end
        if (m_stall && mcnt < (1 << CW) - 1) mcnt++;
    endtask

    task automatic settle();
        #1;
        model_eval();
        chk("sel", 64'(bus.fwd_sel_o), 64'(m_sel));
        chk("stall", 64'(bus.stall_o), 64'(m_stall));
        chk("entry_valid", 64'(bus.entry_valid_o), 64'(m_ev));
        chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(mcnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drv(input logic v, input logic wr, input int dst,
                       input int rdy, input int s0, input int s1,
                       input int s2, input logic [2:0] rd,
                       input logic adv, input logic fl);
        bus.id_valid_i       = v;
        bus.id_wr_en_i       = wr;
        bus.id_dst_i         = RS'(dst);
        bus.id_ready_stage_i = TW'(rdy);
        bus.id_src_i         = {RS'(s2), RS'(s1), RS'(s0)};
        bus.id_rd_src_i      = rd;
        bus.advance_i        = adv;
        bus.flush_i          = fl;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rsn      = 1'b0;
        model_reset();
        drv(1'b0, 1'b0, 0, 0, 0, 0, 0, 3'b000, 1'b1, 1'b0);
        #3;
        chk("rst_sel", 64'(bus.fwd_sel_o), 64'h0);
        chk("rst_stall", 64'(bus.stall_o), 64'h0);
        chk("rst_ev", 64'(bus.entry_valid_o), 64'h0);
        chk("rst_cnt", 64'(bus.stall_cnt_o), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rsn = 1'b1;

        // ALU chain: single-cycle producer forwards from EX.
        drv(1'b1, 1'b1, 5, 0, 0, 0, 0, 3'b000, 1'b1, 1'b0);
        settle(); tick();
        drv(1'b1, 1'b0, 0, 0, 5, 5, 0, 3'b011, 1'b1, 1'b0);
        settle();
        chk("t1_sel", 64'(bus.fwd_sel_o), 64'h05);
        chk("t1_stall", 64'(bus.stall_o), 64'h0);
        tick();

        // Load-use: one stall then forward from MEM.
        drv(1'b1, 1'b1, 7, 1, 0, 0, 0, 3'b000, 1'b1, 1'b0);
        settle(); tick();
        drv(1'b1, 1'b1, 8, 0, 7, 1, 0, 3'b011, 1'b1, 1'b0);
        settle();
        chk("t2_stall", 64'(bus.stall_o), 64'h1);
        tick();
        settle();
        chk("t2_sel", 64'(bus.fwd_sel_o), 64'h02);
        chk("t2_nostall", 64'(bus.stall_o), 64'h0);
        chk("t2_cnt", 64'(bus.stall_cnt_o), 64'h1);
        tick();

        // Youngest producer wins over an older one.
        drv(1'b1, 1'b1, 9, 0, 0, 0, 0, 3'b000, 1'b1, 1'b0);
        settle(); tick();
        drv(1'b1, 1'b1, 4, 0, 0, 0, 0, 3'b000, 1'b1, 1'b0);
        settle(); tick();
        drv(1'b1, 1'b1, 9, 0, 0, 0, 0, 3'b000, 1'b1, 1'b0);
        settle(); tick();
        drv(1'b1, 1'b0, 0, 0, 9, 0, 0, 3'b001, 1'b1, 1'b0);
        settle();
        chk("t3_sel", 64'(bus.fwd_sel_o), 64'h01);
        tick();

        // x0 is never tracked.
        drv(1'b1, 1'b1, 0, 0, 0, 0, 0, 3'b001, 1'b1, 1'b0);
        settle();
        chk("t4_sel", 64'(bus.fwd_sel_o), 64'h0);
        chk("t4_stall", 64'(bus.stall_o), 64'h0);
        tick();
        drv(1'b0, 1'b0, 0, 0, 0, 0, 0, 3'b000, 1'b1, 1'b0);
        settle();
        chk("t4_ev0", 64'(bus.entry_valid_o[0]), 64'h0);
        tick();

        // Hold and flush.
        drv(1'b1, 1'b1, 10, 0, 0, 0, 0, 3'b000, 1'b1, 1'b0);
        settle(); tick();
        drv(1'b1, 1'b1, 11, 0, 0, 0, 0, 3'b000, 1'b1, 1'b0);
        settle(); tick();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 20, 0, 3, 0, 0, 3'b001, 1'b0, 1'b0);
            settle();
            chk("t5_hold", 64'(bus.entry_valid_o), 64'h3);
            tick();
        end
        drv(1'b1, 1'b1, 12, 0, 0, 0, 0, 3'b000, 1'b1, 1'b1);
        settle(); tick();
        drv(1'b0, 1'b0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 1'b0);
        settle();
        chk("t5_flush", 64'(bus.entry_valid_o), 64'h6);
        tick();

        // Saturating counter, then asynchronous reset mid-stall.
        rsn = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rsn = 1'b1;
        drv(1'b1, 1'b1, 13, 2, 0, 0, 0, 3'b000, 1'b1, 1'b0);
        settle(); tick();
        drv(1'b1, 1'b0, 0, 0, 13, 0, 0, 3'b001, 1'b0, 1'b0);
        repeat (20) begin
            settle(); tick();
        end
        settle();
        chk("t6_sat", 64'(bus.stall_cnt_o), 64'hf);
        chk("t6_stall", 64'(bus.stall_o), 64'h1);
        #1;
        rsn = 1'b0;
        #1;
        chk("t6_rst_cnt", 64'(bus.stall_cnt_o), 64'h0);
        chk("t6_rst_ev", 64'(bus.entry_valid_o), 64'h0);
        chk("t6_rst_stall", 64'(bus.stall_o), 64'h0);
        chk("t6_rst_sel", 64'(bus.fwd_sel_o), 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rsn = 1'b1;

        // Random traffic over a small register window to force hits.
        for (int n = 0; n < 3000; n++) begin
            drv($urandom_range(0, 9) < 8,
                $urandom_range(0, 9) < 7,
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)),
                $urandom_range(0, 19) < 17,
                $urandom_range(0, 9) == 0);
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
